// File: rtl/step_dir_pkg.sv
// Shared definitions for the step/dir receive path: state encoding, widths and
// the direction polarity that must agree with the pulse generator.
package step_dir_pkg;

    localparam int POS_W = 32;
    localparam logic [31:0] PERIOD_SAT = 32'hFFFF_FFFF;

    // dir level that means "count down"; the generator drives the same level
    localparam logic DIR_NEG = 1'b1;

    localparam logic [1:0] MASK_CYCLES = 2'd3;

    typedef enum logic [1:0] {
        IDLE,
        FIRST,
        RUN
    } state_t;

    // True when one more step in the given direction flips the sign bit.
    function automatic logic crosses_sign(input logic [POS_W-1:0] pos, input logic dir);
        if (dir == DIR_NEG) begin
            return pos == {1'b1, {(POS_W-1){1'b0}}};
        end
        return pos == {1'b0, {(POS_W-1){1'b1}}};
    endfunction

endpackage

// File: rtl/step_dir_sync.sv
// Brings the asynchronous step/dir pair into the clk domain and produces a
// one-cycle step edge plus a dir-changed pulse.
module step_dir_sync
    import step_dir_pkg::*;
(
    input  logic clk,
    input  logic reset,
    input  logic step_in,
    input  logic dir_in,
    output logic step_edge,
    output logic dir_s,
    output logic dir_changed
);

    logic       step_s1;
    logic       step_s2;
    logic       step_s3;
    logic       dir_s1;
    logic       dir_s2;
    logic       dir_s3;
    logic [1:0] mask_cnt;

    always_ff @(posedge clk) begin
        if (reset) begin
            step_s1  <= 1'b0;
            step_s2  <= 1'b0;
            step_s3  <= 1'b0;
            dir_s1   <= 1'b0;
            dir_s2   <= 1'b0;
            dir_s3   <= 1'b0;
            mask_cnt <= 2'd0;
        end else begin
            step_s1 <= step_in;
            step_s2 <= step_s1;
            step_s3 <= step_s2;
            dir_s1  <= dir_in;
            dir_s2  <= dir_s1;
            dir_s3  <= dir_s2;
            if (mask_cnt != MASK_CYCLES) begin
                mask_cnt <= mask_cnt + 2'd1;
            end
        end
    end

    // A step line already high when reset lifts would otherwise look like a rising edge.
    assign step_edge   = step_s2 & ~step_s3 & (mask_cnt == MASK_CYCLES);
    assign dir_s       = dir_s2;
    assign dir_changed = dir_s2 ^ dir_s3;

endmodule

// File: rtl/step_dir_decoder.sv
// Receive-side step/dir decoder: signed position accumulator, step period
// measurement, direction-setup checking and motion detection.
module step_dir_decoder
    import step_dir_pkg::*;
#(
    parameter int DIR_SETUP    = 4,
    parameter int IDLE_TIMEOUT = 1_000_000
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    step_in,
    input  logic                    dir_in,
    input  logic                    load,
    input  logic signed [POS_W-1:0] load_value,
    input  logic                    err_clear,
    output logic signed [POS_W-1:0] position,
    output logic [31:0]             step_period,
    output logic                    period_valid,
    output logic                    moving,
    output logic                    dir_err,
    output logic                    wrap
);

    localparam int AGE_W = (DIR_SETUP < 1) ? 1 : $clog2(DIR_SETUP + 1);
    localparam logic [AGE_W-1:0] AGE_MAX = AGE_W'(DIR_SETUP);
    localparam logic [31:0] TIMEOUT = 32'(IDLE_TIMEOUT);

    logic             step_edge;
    logic             dir_s;
    logic             dir_changed;
    logic [AGE_W-1:0] dir_age;
    logic [31:0]      gap;
    state_t           state;
    logic             setup_short;
    logic             wrap_hit;
    logic [POS_W-1:0] step_delta;

    step_dir_sync u_sync (
        .clk         (clk),
        .reset       (reset),
        .step_in     (step_in),
        .dir_in      (dir_in),
        .step_edge   (step_edge),
        .dir_s       (dir_s),
        .dir_changed (dir_changed)
    );

    assign setup_short = (dir_age < AGE_MAX);
    assign step_delta  = (dir_s == DIR_NEG) ? {POS_W{1'b1}} : POS_W'(1);
    // A load in the same cycle replaces the position, so that step cannot wrap it.
    assign wrap_hit    = step_edge & ~load & crosses_sign(position, dir_s);

    always_ff @(posedge clk) begin
        if (reset) begin
            dir_age <= '0;
        end else if (dir_changed) begin
            dir_age <= '0;
        end else if (dir_age != AGE_MAX) begin
            dir_age <= dir_age + AGE_W'(1);
        end
    end

    // Setting a flag wins over clearing it so a violation is never lost.
    always_ff @(posedge clk) begin
        if (reset) begin
            position <= '0;
            dir_err  <= 1'b0;
            wrap     <= 1'b0;
        end else begin
            if (load) begin
                position <= load_value;
            end else if (step_edge) begin
                position <= position + step_delta;
            end

            if (step_edge && setup_short) begin
                dir_err <= 1'b1;
            end else if (err_clear) begin
                dir_err <= 1'b0;
            end

            if (wrap_hit) begin
                wrap <= 1'b1;
            end else if (err_clear) begin
                wrap <= 1'b0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state        <= IDLE;
            gap          <= '0;
            step_period  <= '0;
            period_valid <= 1'b0;
            moving       <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (step_edge) begin
                        state  <= FIRST;
                        gap    <= 32'd1;
                        moving <= 1'b1;
                    end
                end
                FIRST, RUN: begin
                    if (step_edge) begin
                        state        <= RUN;
                        step_period  <= gap;
                        period_valid <= 1'b1;
                        gap          <= 32'd1;
                    end else if (gap >= TIMEOUT) begin
                        // Last measured period stays readable after the motor stops.
                        state        <= IDLE;
                        moving       <= 1'b0;
                        period_valid <= 1'b0;
                    end else if (gap != PERIOD_SAT) begin
                        gap <= gap + 32'd1;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_step_dir_decoder.sv
// Scoreboard bench for step_dir_decoder: stimulus queues the expected output
// state, a monitor pops one entry every time the DUT outputs change.
module tb_step_dir_decoder;

    localparam int DIR_SETUP    = 4;
    localparam int IDLE_TIMEOUT = 200;

    logic               clk = 1'b0;
    logic               reset;
    logic               step_in;
    logic               dir_in;
    logic               load;
    logic signed [31:0] load_value;
    logic               err_clear;
    logic signed [31:0] position;
    logic [31:0]        step_period;
    logic               period_valid;
    logic               moving;
    logic               dir_err;
    logic               wrap;

    typedef struct {
        string       name;
        logic [31:0] pos;
        logic [31:0] per;
        logic [3:0]  flags;
    } exp_t;

    exp_t exp_q[$];
    int   vectors     = 0;
    int   miscompares = 0;
    bit   armed       = 1'b0;

    always #5 clk = ~clk;

    step_dir_decoder #(
        .DIR_SETUP    (DIR_SETUP),
        .IDLE_TIMEOUT (IDLE_TIMEOUT)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .step_in      (step_in),
        .dir_in       (dir_in),
        .load         (load),
        .load_value   (load_value),
        .err_clear    (err_clear),
        .position     (position),
        .step_period  (step_period),
        .period_valid (period_valid),
        .moving       (moving),
        .dir_err      (dir_err),
        .wrap         (wrap)
    );

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic expect_out(input string name, input logic [31:0] pos, input logic [31:0] per,
                              input logic pv, input logic mv, input logic de, input logic wr);
        exp_t e;
        e.name  = name;
        e.pos   = pos;
        e.per   = per;
        e.flags = {pv, mv, de, wr};
        exp_q.push_back(e);
    endtask

    task automatic check_output(input exp_t e, input logic [67:0] cur);
        vectors++;
        if (cur !== {e.pos, e.per, e.flags}) begin
            miscompares++;
            $display("[TB] FAIL %s: got pos=%h period=%0d pv/mv/de/wr=%b, expected pos=%h period=%0d pv/mv/de/wr=%b",
                     e.name, cur[67:36], cur[35:4], cur[3:0], e.pos, e.per, e.flags);
        end
    endtask

    task automatic step_pulse(input int high, input int low);
        step_in = 1'b1;
        tick(high);
        step_in = 1'b0;
        tick(low);
    endtask

    task automatic apply_load(input logic [31:0] v);
        load_value = v;
        load       = 1'b1;
        tick(1);
        load       = 1'b0;
        tick(2);
    endtask

    task automatic apply_clear();
        err_clear = 1'b1;
        tick(1);
        err_clear = 1'b0;
        tick(2);
    endtask

    // Monitor: every change of the output bundle consumes one scoreboard entry.
    initial begin
        logic [67:0] last;
        logic [67:0] cur;
        exp_t        e;
        wait (armed);
        @(negedge clk);
        cur = {position, step_period, period_valid, moving, dir_err, wrap};
        e   = exp_q.pop_front();
        check_output(e, cur);
        last = cur;
        forever begin
            @(negedge clk);
            cur = {position, step_period, period_valid, moving, dir_err, wrap};
            if (cur !== last) begin
                if (exp_q.size() == 0) begin
                    vectors++;
                    miscompares++;
                    $display("[TB] FAIL unexpected_change: got pos=%h period=%0d pv/mv/de/wr=%b, expected no change",
                             cur[67:36], cur[35:4], cur[3:0]);
                end else begin
                    e = exp_q.pop_front();
                    check_output(e, cur);
                end
                last = cur;
            end
        end
    end

    initial begin
        exp_t e;
        reset      = 1'b1;
        step_in    = 1'b0;
        dir_in     = 1'b0;
        load       = 1'b0;
        load_value = '0;
        err_clear  = 1'b0;
        expect_out("reset", 32'h0, 32'd0, 0, 0, 0, 0);
        tick(3);
        armed = 1'b1;
        reset = 1'b0;
        tick(10);

        // 10 forward steps, period 20, then stop
        for (int i = 1; i <= 10; i++) begin
            expect_out($sformatf("fwd_step%0d", i), 32'(i), (i == 1) ? 32'd0 : 32'd20, i > 1, 1, 0, 0);
        end
        repeat (10) step_pulse(10, 10);
        expect_out("fwd_timeout", 32'd10, 32'd20, 0, 0, 0, 0);
        tick(250);

        // load 5, 8 reverse steps
        expect_out("load5", 32'd5, 32'd20, 0, 0, 0, 0);
        apply_load(32'd5);
        dir_in = 1'b1;
        tick(10);
        for (int i = 1; i <= 8; i++) begin
            expect_out($sformatf("rev_step%0d", i), 32'(5 - i), 32'd20, i > 1, 1, 0, 0);
        end
        repeat (8) step_pulse(10, 10);
        expect_out("rev_timeout", 32'hFFFF_FFFD, 32'd20, 0, 0, 0, 0);
        tick(250);

        // positive wrap and its clear
        expect_out("load_max", 32'h7FFF_FFFF, 32'd20, 0, 0, 0, 0);
        apply_load(32'h7FFF_FFFF);
        dir_in = 1'b0;
        tick(10);
        expect_out("wrap_set", 32'h8000_0000, 32'd20, 0, 1, 0, 1);
        step_pulse(10, 10);
        expect_out("wrap_clear", 32'h8000_0000, 32'd20, 0, 1, 0, 0);
        apply_clear();
        expect_out("wrap_timeout", 32'h8000_0000, 32'd20, 0, 0, 0, 0);
        tick(250);

        // dir setup: 2 clk is too short, 6 clk is enough
        expect_out("load0", 32'h0, 32'd20, 0, 0, 0, 0);
        apply_load(32'h0);
        expect_out("setup_short", 32'hFFFF_FFFF, 32'd20, 0, 1, 1, 0);
        dir_in = 1'b1;
        tick(2);
        step_pulse(10, 10);
        expect_out("setup_ok", 32'h0, 32'd26, 1, 1, 1, 0);
        dir_in = 1'b0;
        tick(6);
        step_pulse(10, 10);
        expect_out("dir_err_clear", 32'h0, 32'd26, 1, 1, 0, 0);
        apply_clear();
        expect_out("setup_timeout", 32'h0, 32'd26, 0, 0, 0, 0);
        tick(250);

        // load coincident with an accepted edge
        expect_out("load_vs_edge", 32'h1234_5678, 32'd26, 0, 1, 0, 0);
        step_in = 1'b1;
        tick(2);
        load_value = 32'h1234_5678;
        load       = 1'b1;
        tick(1);
        load       = 1'b0;
        tick(7);
        step_in = 1'b0;
        tick(10);

        // err_clear coincident with a new dir violation
        expect_out("clear_vs_set", 32'h1234_5677, 32'd22, 1, 1, 1, 0);
        dir_in = 1'b1;
        tick(2);
        step_in = 1'b1;
        tick(2);
        err_clear = 1'b1;
        tick(1);
        err_clear = 1'b0;
        tick(7);
        step_in = 1'b0;
        tick(10);
        expect_out("prio_timeout", 32'h1234_5677, 32'd22, 0, 0, 1, 0);
        tick(250);
        expect_out("prio_clear", 32'h1234_5677, 32'd22, 0, 0, 0, 0);
        apply_clear();

        // reset mid-RUN with step held high, then restart from IDLE
        expect_out("run_first", 32'h1234_5676, 32'd22, 0, 1, 0, 0);
        expect_out("run_second", 32'h1234_5675, 32'd20, 1, 1, 0, 0);
        repeat (2) step_pulse(10, 10);
        expect_out("mid_reset", 32'h0, 32'd0, 0, 0, 0, 0);
        step_in = 1'b1;
        reset   = 1'b1;
        tick(3);
        reset = 1'b0;
        tick(20);
        step_in = 1'b0;
        tick(10);
        expect_out("restart_first", 32'hFFFF_FFFF, 32'd0, 0, 1, 0, 0);
        expect_out("restart_run", 32'hFFFF_FFFE, 32'd20, 1, 1, 0, 0);
        repeat (2) step_pulse(10, 10);
        expect_out("restart_timeout", 32'hFFFF_FFFE, 32'd20, 0, 0, 0, 0);
        tick(250);

        tick(5);
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            vectors++;
            miscompares++;
            $display("[TB] FAIL %s: got no output change, expected pos=%h period=%0d pv/mv/de/wr=%b",
                     e.name, e.pos, e.per, e.flags);
        end
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
